// File: rtl/adpcm_pkg.sv
// Shared constants, step tables and FSM encoding for the ADPCM predictor path.
package adpcm_pkg;

    localparam int unsigned PRED_W  = 16;
    localparam int unsigned STEP_W  = 16;
    localparam int unsigned INDEX_W = 7;
    localparam int unsigned ACC_W   = 17;
    localparam int unsigned SUM_W   = 18;
    localparam int unsigned ADJ_W   = 5;
    localparam int unsigned NSTEPS  = 89;

    localparam logic [INDEX_W-1:0] MAX_INDEX = 7'd88;

    // IMA ADPCM step sizes indexed by step_index
    localparam logic [STEP_W-1:0] STEP_TABLE [0:NSTEPS-1] = '{
        16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,    16'd16,    16'd17,
        16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,    16'd34,    16'd37,    16'd41,    16'd45,
        16'd50,    16'd55,    16'd60,    16'd66,    16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,
        16'd130,   16'd143,   16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
        16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,   16'd724,   16'd796,
        16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,  16'd1552,  16'd1707,  16'd1878,  16'd2066,
        16'd2272,  16'd2499,  16'd2749,  16'd3024,  16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,
        16'd5894,  16'd6484,  16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
        16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794, 16'd32767
    };

    // Step-index adjustment per code magnitude
    localparam logic signed [ADJ_W-1:0] ADJ [0:7] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADD2   = 3'd1,
        ST_ADD1   = 3'd2,
        ST_ADD0   = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

endpackage

// File: rtl/adpcm_step_adapt.sv
// Combinational step-index adaptation: clamped next index and its step size.
module adpcm_step_adapt
    import adpcm_pkg::*;
(
    input  logic [INDEX_W-1:0] i_index,
    input  logic [2:0]         i_mag,
    output logic [INDEX_W-1:0] o_index_c,
    output logic [STEP_W-1:0]  o_step_c
);

    logic signed [ADJ_W-1:0]   w_adj;
    logic signed [INDEX_W:0]   w_sum;
    logic [INDEX_W-1:0]        w_index;

    // Apply the table adjustment and clamp into [0, MAX_INDEX]
    always_comb begin
        w_adj   = ADJ[i_mag];
        w_sum   = $signed({1'b0, i_index}) + $signed({{(INDEX_W+1-ADJ_W){w_adj[ADJ_W-1]}}, w_adj});
        w_index = w_sum[INDEX_W-1:0];
        if (w_sum < $signed((INDEX_W+1)'(0))) begin
            w_index = '0;
        end else if (w_sum > $signed({1'b0, MAX_INDEX})) begin
            w_index = MAX_INDEX;
        end
    end

    assign o_index_c = w_index;
    assign o_step_c  = STEP_TABLE[w_index];

endmodule

// File: rtl/adpcm_predictor.sv
// ADPCM reconstruction stage: dequantizes a 4-bit code with a shift-add
// sequence, updates the saturating predicted sample and the step index.
module adpcm_predictor
    import adpcm_pkg::*;
#(
    parameter logic signed [15:0] INIT_PRED  = 16'sd0,
    parameter logic [6:0]         INIT_INDEX = 7'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     code_valid,
    input  logic [3:0]               code,
    output logic                     code_ready,
    output logic signed [PRED_W-1:0] predicted,
    output logic [STEP_W-1:0]        step_size,
    output logic [INDEX_W-1:0]       step_index,
    output logic                     recon_valid
);

    localparam logic [STEP_W-1:0] INIT_STEP = STEP_TABLE[INIT_INDEX];

    state_t                    r_state;
    logic                      r_ready;
    logic                      r_recon;
    logic signed [PRED_W-1:0]  r_pred;
    logic [INDEX_W-1:0]        r_index;
    logic [STEP_W-1:0]         r_step;
    logic [3:0]                r_code;
    logic [ACC_W-1:0]          r_acc;

    logic signed [SUM_W-1:0]   w_pred_ext;
    logic signed [SUM_W-1:0]   w_acc_ext;
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [PRED_W-1:0]  w_pred_sat;
    logic [INDEX_W-1:0]        w_new_index;
    logic [STEP_W-1:0]         w_new_step;

    adpcm_step_adapt u_step_adapt (
        .i_index   (r_index),
        .i_mag     (r_code[2:0]),
        .o_index_c (w_new_index),
        .o_step_c  (w_new_step)
    );

    // Signed predictor update with saturation to the 16-bit sample range
    always_comb begin
        w_pred_ext = $signed({{(SUM_W-PRED_W){r_pred[PRED_W-1]}}, r_pred});
        w_acc_ext  = $signed({{(SUM_W-ACC_W){1'b0}}, r_acc});
        w_sum      = r_code[3] ? (w_pred_ext - w_acc_ext) : (w_pred_ext + w_acc_ext);
        w_pred_sat = w_sum[PRED_W-1:0];
        if (w_sum > 18'sd32767) begin
            w_pred_sat = 16'sh7FFF;
        end else if (w_sum < -18'sd32768) begin
            w_pred_sat = 16'sh8000;
        end
    end

    // Control FSM and shift-add datapath; outputs only move at COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_recon <= 1'b0;
            r_pred  <= INIT_PRED;
            r_index <= INIT_INDEX;
            r_step  <= INIT_STEP;
            r_code  <= '0;
            r_acc   <= '0;
        end else if (clear) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_recon <= 1'b0;
            r_pred  <= INIT_PRED;
            r_index <= INIT_INDEX;
            r_step  <= INIT_STEP;
            r_code  <= '0;
            r_acc   <= '0;
        end else begin
            r_recon <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (code_valid && r_ready) begin
                        r_code  <= code;
                        r_acc   <= ACC_W'(r_step >> 3);
                        r_ready <= 1'b0;
                        r_state <= ST_ADD2;
                    end
                end
                ST_ADD2: begin
                    if (r_code[2]) r_acc <= r_acc + ACC_W'(r_step);
                    r_state <= ST_ADD1;
                end
                ST_ADD1: begin
                    if (r_code[1]) r_acc <= r_acc + ACC_W'(r_step >> 1);
                    r_state <= ST_ADD0;
                end
                ST_ADD0: begin
                    if (r_code[0]) r_acc <= r_acc + ACC_W'(r_step >> 2);
                    r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_pred  <= w_pred_sat;
                    r_index <= w_new_index;
                    r_step  <= w_new_step;
                    r_recon <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign code_ready  = r_ready;
    assign predicted   = r_pred;
    assign step_size   = r_step;
    assign step_index  = r_index;
    assign recon_valid = r_recon;

endmodule

// File: tb/tb_adpcm_predictor.sv
// Directed bench for adpcm_predictor: vector table plus multi-cycle corner sequences.
module tb_adpcm_predictor;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        code_valid;
    logic [3:0]  code;

    logic        m_ready, h_ready, l_ready;
    logic        m_recon, h_recon, l_recon;
    logic [15:0] m_pred, h_pred, l_pred;
    logic [15:0] m_step, h_step, l_step;
    logic [6:0]  m_idx, h_idx, l_idx;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] pred;
        logic [6:0]  idx;
        logic [15:0] step;
    } vec_t;

    vec_t vecs [9];

    adpcm_predictor u_dut (
        .clk (clk), .rst_n (rst_n), .clear (clear),
        .code_valid (code_valid), .code (code), .code_ready (m_ready),
        .predicted (m_pred), .step_size (m_step), .step_index (m_idx),
        .recon_valid (m_recon)
    );

    adpcm_predictor #(.INIT_PRED(16'sh7FFF), .INIT_INDEX(7'd88)) u_sat_hi (
        .clk (clk), .rst_n (rst_n), .clear (clear),
        .code_valid (code_valid), .code (code), .code_ready (h_ready),
        .predicted (h_pred), .step_size (h_step), .step_index (h_idx),
        .recon_valid (h_recon)
    );

    adpcm_predictor #(.INIT_PRED(16'sh8000), .INIT_INDEX(7'd88)) u_sat_lo (
        .clk (clk), .rst_n (rst_n), .clear (clear),
        .code_valid (code_valid), .code (code), .code_ready (l_ready),
        .predicted (l_pred), .step_size (l_step), .step_index (l_idx),
        .recon_valid (l_recon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        clear      = 1'b0;
        code_valid = 1'b0;
        code       = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one code, check handshake, latency and single recon pulse
    task automatic send(input logic [3:0] c);
        int  n;
        bit  seen;
        @(negedge clk);
        code_valid = 1'b1;
        code       = c;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code       = 4'h0;
        chk("ready_busy", 32'(m_ready), 32'd0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (m_recon) seen = 1'b1;
        end
        chk("latency", 32'(n), 32'd4);
        chk("ready_after", 32'(m_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("recon_single", 32'(m_recon), 32'd0);
    endtask

    task automatic chk_state(input string nm, input logic [15:0] p, input logic [6:0] i,
                             input logic [15:0] s);
        chk({nm, "_pred"}, 32'(m_pred), 32'(p));
        chk({nm, "_idx"},  32'(m_idx),  32'(i));
        chk({nm, "_step"}, 32'(m_step), 32'(s));
    endtask

    initial begin
        int pulses;
        n_cmp  = 0;
        n_fail = 0;

        vecs[0] = '{4'h7, 16'd11,   7'd8,  16'd16};
        vecs[1] = '{4'hF, 16'hFFED, 7'd16, 16'd34};
        vecs[2] = '{4'h4, 16'd19,   7'd18, 16'd41};
        vecs[3] = '{4'h0, 16'd24,   7'd17, 16'd37};
        vecs[4] = '{4'h8, 16'd20,   7'd16, 16'd34};
        vecs[5] = '{4'hB, 16'hFFF7, 7'd15, 16'd31};
        vecs[6] = '{4'h5, 16'd32,   7'd19, 16'd45};
        vecs[7] = '{4'hE, 16'hFFD8, 7'd25, 16'd80};
        vecs[8] = '{4'h6, 16'd90,   7'd31, 16'd143};

        rst_n      = 1'b0;
        clear      = 1'b0;
        code_valid = 1'b0;
        code       = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_state("reset", 16'd0, 7'd0, 16'd7);
        chk("reset_ready", 32'(m_ready), 32'd1);
        chk("reset_recon", 32'(m_recon), 32'd0);

        // Single positive code from reset
        send(4'h4);
        chk_state("code4", 16'd7, 7'd2, 16'd9);

        // Zero code: no change to prediction, index clamps at 0
        do_reset();
        send(4'h0);
        chk_state("code0", 16'd0, 7'd0, 16'd7);

        // code_valid held high: one acceptance every 5 cycles
        @(negedge clk);
        code_valid = 1'b1;
        code       = 4'h0;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk);
            #1;
            chk("hold_ready", 32'(m_ready), 32'(e % 5 == 0));
            chk("hold_recon", 32'(m_recon), 32'(e % 5 == 0));
        end
        @(negedge clk);
        code_valid = 1'b0;

        // Cumulative vector table from reset
        do_reset();
        for (int k = 0; k < 9; k++) begin
            send(vecs[k].code);
            chk_state($sformatf("vec%0d", k), vecs[k].pred, vecs[k].idx, vecs[k].step);
        end

        // clear during ADD1, with a competing code_valid in the same cycle
        @(negedge clk);
        code_valid = 1'b1;
        code       = 4'h4;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        clear      = 1'b1;
        code_valid = 1'b1;
        code       = 4'h7;
        @(posedge clk);
        #1;
        clear      = 1'b0;
        code_valid = 1'b0;
        chk_state("clear", 16'd0, 7'd0, 16'd7);
        chk("clear_ready", 32'(m_ready), 32'd1);
        chk("clear_recon", 32'(m_recon), 32'd0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (m_recon) pulses++;
        end
        chk("clear_no_recon", 32'(pulses), 32'd0);
        chk("clear_idle_ready", 32'(m_ready), 32'd1);
        chk("clear_pred_hold", 32'(m_pred), 32'd0);

        // Asynchronous reset while in ADD0
        send(4'h7);
        chk_state("pre_rst", 16'd11, 7'd8, 16'd16);
        @(negedge clk);
        code_valid = 1'b1;
        code       = 4'h7;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("arst", 16'd0, 7'd0, 16'd7);
        chk("arst_ready", 32'(m_ready), 32'd1);
        chk("arst_recon", 32'(m_recon), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (m_recon) pulses++;
        end
        chk("arst_no_recon", 32'(pulses), 32'd0);

        // Positive saturation at max index
        do_reset();
        send(4'h7);
        chk("sat_hi_pred", 32'(h_pred), 32'h7FFF);
        chk("sat_hi_idx",  32'(h_idx),  32'd88);
        chk("sat_hi_step", 32'(h_step), 32'd32767);

        // Negative saturation at max index
        do_reset();
        send(4'hF);
        chk("sat_lo_pred", 32'(l_pred), 32'h8000);
        chk("sat_lo_idx",  32'(l_idx),  32'd88);
        chk("sat_lo_step", 32'(l_step), 32'd32767);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
